// File: rtl/pwm_ramp_pkg.sv
// Shared types, widths and saturating step helpers for the PWM ramp sequencer.
package pwm_ramp_pkg;

  localparam int unsigned DUTY_W           = 8;
  localparam int unsigned STEP_W           = 4;
  // 10 ms per ramp step at 25 MHz.
  localparam int unsigned TICK_DIV_DEFAULT = 250000;

  typedef enum logic [1:0] {
    StIdle,
    StRampUp,
    StRampDn,
    StDone
  } state_e;

  // duty + step, clamped at lim; evaluated one bit wider so 255 + 15 cannot wrap.
  function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] duty,
                                               input logic [STEP_W-1:0] stp,
                                               input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] sum;
    sum = {1'b0, duty} + {{(DUTY_W + 1 - STEP_W){1'b0}}, stp};
    return (sum >= {1'b0, lim}) ? lim : sum[DUTY_W-1:0];
  endfunction

  // duty - step, clamped at lim; the extra MSB flags an underflow below zero.
  function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] duty,
                                               input logic [STEP_W-1:0] stp,
                                               input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] diff;
    diff = {1'b0, duty} - {{(DUTY_W + 1 - STEP_W){1'b0}}, stp};
    return (diff[DUTY_W] || (diff <= {1'b0, lim})) ? lim : diff[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running step-rate divider: tick is high for one cycle every TICK_DIV cycles
// while clr is low. clr restarts the count from zero.
module tick_div #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..TICK_DIV-1, wrapping; held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = !clr && (cnt_q == CntMax);

endmodule

// File: rtl/pwm_ramp_seq.sv
// Ramps an 8-bit PWM/display duty value toward a target in saturating steps,
// one step per divided tick, with abort and a one-cycle completion pulse.
module pwm_ramp_seq
  import pwm_ramp_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic              sys_clk_pin,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target,
  input  logic [STEP_W-1:0] step,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] tgt_q;
  logic [STEP_W-1:0] step_q;
  logic              busy_q;
  logic              done_q;

  logic              tick;
  logic              tick_clr;
  logic [DUTY_W-1:0] up_val;
  logic [DUTY_W-1:0] dn_val;

  // Divider only runs in the ramp states, so it restarts from zero on every entry.
  assign tick_clr = (state_q != StRampUp) && (state_q != StRampDn);

  tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk (sys_clk_pin),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  assign up_val = sat_up(duty_q, step_q, tgt_q);
  assign dn_val = sat_dn(duty_q, step_q, tgt_q);

  // Sequencer FSM with registered duty, busy and done.
  always_ff @(posedge sys_clk_pin) begin
    if (rst) begin
      state_q <= StIdle;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            tgt_q  <= target;
            // A zero step would never converge; treat it as 1.
            step_q <= (step == '0) ? STEP_W'(1) : step;
            if (target > duty_q) begin
              state_q <= StRampUp;
              busy_q  <= 1'b1;
            end else if (target < duty_q) begin
              state_q <= StRampDn;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRampUp: begin
          // abort beats a coincident tick: duty is left untouched.
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tick) begin
            duty_q <= up_val;
            if (up_val == tgt_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StRampDn: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (tick) begin
            duty_q <= dn_val;
            if (dn_val == tgt_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Scoreboard bench for pwm_ramp_seq with TICK_DIV=4. Stimulus pushes the expected
// duty/busy/done events with their cycle numbers; the monitor pops one whenever
// duty_out changes or done is high.
module tb_pwm_ramp_seq;

  logic       sys_clk_pin = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] target;
  logic [3:0] step;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  always #5 sys_clk_pin = ~sys_clk_pin;

  pwm_ramp_seq #(
    .TICK_DIV(4)
  ) dut (
    .sys_clk_pin(sys_clk_pin),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .target     (target),
    .step       (step),
    .duty_out   (duty_out),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] duty;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_duty;

  always @(posedge sys_clk_pin) cyc <= cyc + 1;

  // Monitor: an event is any duty change or a done pulse.
  always @(negedge sys_clk_pin) begin : monitor
    exp_t e;
    if (mon_en && ((duty_out !== prev_duty) || (done === 1'b1))) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cyc=%0d duty=%0d busy=%0b done=%0b, none expected",
                 cyc, duty_out, busy, done);
      end else begin
        e = q.pop_front();
        if (duty_out !== e.duty || busy !== e.busy || done !== e.done || cyc != e.cyc) begin
          fails++;
          $display("FAIL %s: got cyc=%0d duty=%0d busy=%0b done=%0b, expected cyc=%0d duty=%0d busy=%0b done=%0b",
                   e.name, cyc, duty_out, busy, done, e.cyc, e.duty, e.busy, e.done);
        end
      end
    end
    prev_duty = duty_out;
  end

  task automatic push_ev(input string n, input int c, input logic [7:0] d, input logic b,
                         input logic dn);
    exp_t e;
    e.name = n;
    e.cyc  = c;
    e.duty = d;
    e.busy = b;
    e.done = dn;
    q.push_back(e);
  endtask

  task automatic check(input string n, input logic [7:0] d, input logic b, input logic dn);
    tests++;
    if (duty_out !== d || busy !== b || done !== dn) begin
      fails++;
      $display("FAIL %s: got duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
               n, duty_out, busy, done, d, b, dn);
    end
  endtask

  // Raises start at the next negedge; returns the edge that samples it.
  task automatic do_start(input logic [7:0] t, input logic [3:0] s, output int s_edge);
    @(negedge sys_clk_pin);
    target = t;
    step   = s;
    start  = 1'b1;
    s_edge = cyc + 1;
  endtask

  task automatic release_start();
    @(negedge sys_clk_pin);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge sys_clk_pin);
  endtask

  task automatic wait_drain(input string n, input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge sys_clk_pin);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", n, q.size());
      q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s;
    int s2;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    step   = '0;

    // Reset held for three edges.
    repeat (3) begin
      @(negedge sys_clk_pin);
      check("reset", 8'd0, 1'b0, 1'b0);
    end
    rst    = 1'b0;
    mon_en = 1'b1;

    // Ramp up 0 -> 10 step 3.
    do_start(8'd10, 4'd3, s);
    push_ev("up_3", s + 4, 8'd3, 1'b1, 1'b0);
    push_ev("up_6", s + 8, 8'd6, 1'b1, 1'b0);
    push_ev("up_9", s + 12, 8'd9, 1'b1, 1'b0);
    push_ev("up_10", s + 16, 8'd10, 1'b0, 1'b1);
    release_start();
    wait_drain("ramp_up", 40);
    wait_cyc(s + 17);
    check("up_idle", 8'd10, 1'b0, 1'b0);

    // Equal target: done one cycle after start, duty unchanged.
    do_start(8'd10, 4'd7, s);
    push_ev("equal_done", s, 8'd10, 1'b0, 1'b1);
    release_start();
    wait_drain("equal", 10);
    wait_cyc(s + 1);
    check("equal_after", 8'd10, 1'b0, 1'b0);

    // 10 -> 250 step 15 (16 ticks), then 250 -> 255 saturating.
    do_start(8'd250, 4'd15, s);
    for (int k = 1; k <= 16; k++)
      push_ev("up_250", s + 4 * k, 8'(10 + 15 * k), (k != 16), (k == 16));
    release_start();
    wait_drain("to_250", 100);
    do_start(8'd255, 4'd15, s);
    push_ev("sat_255", s + 4, 8'd255, 1'b0, 1'b1);
    release_start();
    wait_drain("sat", 20);

    // 255 -> 20 step 15: last step clamps at 20.
    do_start(8'd20, 4'd15, s);
    for (int k = 1; k <= 16; k++)
      push_ev("dn_20", s + 4 * k, (k == 16) ? 8'd20 : 8'(255 - 15 * k), (k != 16), (k == 16));
    release_start();
    wait_drain("to_20", 100);

    // Step 0 acts as 1: 20 -> 0.
    do_start(8'd0, 4'd0, s);
    for (int k = 1; k <= 20; k++)
      push_ev("step0", s + 4 * k, 8'(20 - k), (k != 20), (k == 20));
    release_start();
    wait_drain("step0", 120);

    // Start during RAMP_UP is ignored.
    do_start(8'd10, 4'd3, s);
    push_ev("ign_3", s + 4, 8'd3, 1'b1, 1'b0);
    push_ev("ign_6", s + 8, 8'd6, 1'b1, 1'b0);
    push_ev("ign_9", s + 12, 8'd9, 1'b1, 1'b0);
    push_ev("ign_10", s + 16, 8'd10, 1'b0, 1'b1);
    release_start();
    wait_cyc(s + 5);
    do_start(8'd0, 4'd1, s2);
    release_start();
    wait_drain("ignored", 40);

    // 10 -> 0 step 15: no wrap below zero.
    do_start(8'd0, 4'd15, s);
    push_ev("dn_nowrap", s + 4, 8'd0, 1'b0, 1'b1);
    release_start();
    wait_drain("nowrap", 20);

    // Abort after the second tick.
    do_start(8'd200, 4'd10, s);
    push_ev("ab_10", s + 4, 8'd10, 1'b1, 1'b0);
    push_ev("ab_20", s + 8, 8'd20, 1'b1, 1'b0);
    release_start();
    wait_cyc(s + 8);
    abort = 1'b1;
    @(negedge sys_clk_pin);
    abort = 1'b0;
    check("abort_idle", 8'd20, 1'b0, 1'b0);
    repeat (10) @(negedge sys_clk_pin);
    check("abort_hold", 8'd20, 1'b0, 1'b0);
    wait_drain("abort", 5);

    // Abort coinciding with the first tick: duty must not update.
    do_start(8'd100, 4'd10, s);
    release_start();
    wait_cyc(s + 3);
    abort = 1'b1;
    @(negedge sys_clk_pin);
    abort = 1'b0;
    check("abort_tick", 8'd20, 1'b0, 1'b0);
    repeat (8) @(negedge sys_clk_pin);
    check("abort_tick_hold", 8'd20, 1'b0, 1'b0);

    // Reset mid-ramp.
    do_start(8'd200, 4'd10, s);
    push_ev("rm_30", s + 4, 8'd30, 1'b1, 1'b0);
    push_ev("rm_reset", s + 6, 8'd0, 1'b0, 1'b0);
    release_start();
    wait_cyc(s + 5);
    rst = 1'b1;
    @(negedge sys_clk_pin);
    rst = 1'b0;
    check("rst_mid", 8'd0, 1'b0, 1'b0);
    repeat (10) @(negedge sys_clk_pin);
    check("rst_mid_idle", 8'd0, 1'b0, 1'b0);
    wait_drain("rst_mid", 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_seq.md
PWM_RAMP_SEQ -- requirements
Module: pwm_ramp_seq

Interface
REQ-001 Parameter TICK_DIV, default 250000, sets the number of sys_clk_pin cycles per ramp step (10 ms at 25 MHz); legal range 1..2^24-1.
REQ-002 sys_clk_pin  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin a ramp toward target.
REQ-005 abort  input  1  stops an active ramp.
REQ-006 target  input  8  unsigned duty/display setpoint to ramp toward.
REQ-007 step  input  4  unsigned increment per tick; 0 is treated as 1.
REQ-008 duty_out  output  8  registered value driven to the 8-bit input of the display/PWM datapath.
REQ-009 busy  output  1  high while ramping.
REQ-010 done  output  1  single-cycle completion pulse.

Function
REQ-011 The FSM SHALL have the states IDLE, RAMP_UP, RAMP_DN and DONE.
REQ-012 In IDLE, start=1 SHALL latch target and step and move on the next edge to RAMP_UP if target>duty_out, RAMP_DN if target<duty_out, or DONE if they are equal.
REQ-013 start SHALL be ignored in RAMP_UP, RAMP_DN and DONE, with no effect on the latched target or step.
REQ-014 The tick counter SHALL clear on entry to a ramp state, count 0..TICK_DIV-1, and raise tick when count==TICK_DIV-1; the first duty update occurs TICK_DIV cycles after ramp entry.
REQ-015 On tick in RAMP_UP, duty_out SHALL become min(duty_out+step, target), computed 9 bits wide with no wrap past 255.
REQ-016 On tick in RAMP_DN, duty_out SHALL become max(duty_out-step, target), computed 9 bits wide with no wrap below 0.
REQ-017 On the edge where the updated duty_out equals the target, the FSM SHALL enter DONE in the same edge.
REQ-018 DONE SHALL last exactly one cycle (done=1) and then return to IDLE.
REQ-019 busy SHALL be 1 exactly in RAMP_UP and RAMP_DN; done SHALL be 1 exactly in DONE.
REQ-020 abort=1 in a ramp state SHALL force IDLE on the next edge, hold duty_out, and produce no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-021 If abort and tick coincide, abort SHALL win and duty_out SHALL not update.
REQ-022 duty_out SHALL change only on tick edges or on reset.

Reset
REQ-023 While rst=1 at an edge: state=IDLE, duty_out=0, busy=0, done=0, tick counter=0, latched target and step=0.
REQ-024 rst SHALL take priority over start, abort and tick, including mid-ramp.

Structure
REQ-025 Package pwm_ramp_pkg SHALL hold the state enum, DUTY_W=8, STEP_W=4 and the TICK_DIV default.
REQ-026 The tick generator SHALL be a sub-module named tick_div, with inputs clk, rst and clr, parameter TICK_DIV, and output tick.

Verification (bench overrides TICK_DIV=4)
REQ-027 Reset case: assert rst for 3 cycles -> duty_out=0, busy=0, done=0 on every cycle after the first reset edge.
REQ-028 Ramp up: from duty 0, pulse start with target=10 and step=3 -> duty_out steps 3, 6, 9, 10 at 4-cycle intervals, busy=1 throughout the ramp, done=1 in the same cycle duty_out first reads 10, and IDLE on the next cycle.
REQ-029 Saturation: from duty 250, start with target=255 and step=15 -> duty_out=255 after one tick with no wrap. Step zero: from 20, target=0 and step=0 -> duty_out decrements by 1 per tick down to 0.
REQ-030 Equal and ignored starts: start with target==duty_out -> done pulse 1 cycle later and duty_out unchanged. A start during RAMP_UP with target=0 -> ignored, and the original ramp completes.
REQ-031 Abort and reset mid-ramp: from 0, target=200 and step=10; assert abort after the 2nd tick -> duty_out holds 20, busy=0, no done pulse. Repeat the ramp with rst asserted mid-ramp -> duty_out=0 and state IDLE on the next edge.
